pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and sequencing stage that sits directly downstream of the ALU: it consumes the ALU's `taken` flag together with decoded branch/halt controls and produces the instruction address for the next fetch. It owns the program start/done handshake with the test harness and holds an 8-entry loadable branch-target table for absolute (long) jumps. All outputs are registered; nothing in this block is combinational from input to output except the table read feeding the PC register.

## Interface
- `PC_W`, 10: program-counter width; instruction memory depth is 2^PC_W.
- `LUT_N`, 8: branch-target table entries; index width is log2(LUT_N) = 3.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `start`  in  1  begin a program; level or pulse, acted on only in IDLE or DONE.
- `stall`  in  1  hold PC and ignore `halt_i`/branch controls this cycle.
- `halt_i`  in  1  current instruction is HALT.
- `br_en`  in  1  current instruction is a branch.
- `br_cond`  in  1  1 = branch only if `taken`; 0 = unconditional.
- `br_mode`  in  1  0 = relative (`br_off`), 1 = absolute (`lut[br_idx]`).
- `taken`  in  1  ALU NOR flag (result == 0).
- `br_off`  in  8  signed two's-complement relative offset.
- `br_idx`  in  3  target-table index for absolute branches.
- `lut_we`  in  1  target-table write enable.
- `lut_idx`  in  3  target-table write index.
- `lut_data`  in  PC_W  target-table write data.
- `pc_o`  out  PC_W  current instruction address.
- `running`  out  1  1 while in RUN.
- `done`  out  1  1 while in DONE.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: `pc_o` held 0. `start`=1 -> RUN, `pc_o`=0.
- RUN, priority high to low:
  - `stall`=1: PC holds; `halt_i`, `br_en` ignored.
  - `halt_i`=1: -> DONE; PC holds at the HALT address.
  - `br_en`=1 and (`br_cond`=0 or `taken`=1):
    - `br_mode`=0: PC <= PC + sign_extend(`br_off`), modulo 2^PC_W.
    - `br_mode`=1: PC <= `lut[br_idx]`.
  - Otherwise: PC <= PC + 1, wrapping 2^PC_W-1 -> 0.
- RUN ignores `start`.
- DONE: PC frozen, `done`=1. `start`=1 -> RUN with `pc_o`=0 and `done`=0 (back-to-back programs without reset).
- Target table: LUT_N x PC_W registers.
  - Writes happen in any state, including during `stall`.
  - A read in the same cycle as a write to the same index returns the old value.
- Relative arithmetic: offset range -128..+127. Sum is computed at PC_W bits and truncated; no overflow flag.
- Conditional branch with `taken`=0 falls through to PC+1.
- Controls are don't-care outside RUN.

## Timing
- Reset values: `pc_o`=0, `running`=0, `done`=0, state IDLE, all table entries 0.
- Reset has priority over every other input on the same edge, including mid-RUN and in DONE.
- Latency: every PC change, state change and flag change appears one cycle after the sampling edge.
- `start` sampled at edge N in IDLE/DONE: `running`=1 and `pc_o`=0 from N+1. The first instruction is fetched at address 0.
- `halt_i` sampled at edge N: `done`=1 and `running`=0 from N+1.
- `running` and `done` are never both 1.
- A table write at edge N is visible to a branch sampled at edge N+1.

## Test plan
- Reset, then `start`=1 for one cycle, then 5 free cycles -> `pc_o` sequence 0,1,2,3,4,5; `running`=1; `done`=0.
- At PC=20: `br_en`=1, `br_cond`=1, `br_mode`=0, `br_off`=0xF6, `taken`=1 -> next `pc_o`=10. Same stimulus with `taken`=0 -> next `pc_o`=21.
- Write `lut[3]`=0x3F0 at PC=7. Next cycle: `br_en`=1, `br_mode`=1, `br_cond`=0, `br_idx`=3 -> next `pc_o`=0x3F0. Same-edge write+branch to index 3 with old value 0 -> next `pc_o`=0.
- At PC=0x3FF with no branch -> next `pc_o`=0. At PC=5 with `br_off`=0x80 -> next `pc_o`=0x385.
- `stall`=1 together with `halt_i`=1 at PC=9 -> `pc_o` stays 9 and `done`=0. Release `stall` with `halt_i` still 1 -> next cycle `done`=1, `pc_o`=9. Then `start`=1 -> `pc_o`=0, `running`=1, `done`=0.
- `reset`=1 mid-RUN at PC=42 with `lut[1]` written -> next cycle `pc_o`=0, IDLE, `lut[1]`=0, `start` required to resume.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter and sequencing stage with start/done handshake
// and an 8-entry loadable absolute branch-target table.
module pc_unit #(
  parameter int PC_W  = 10,
  parameter int LUT_N = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stall,
  input  logic                     halt_i,
  input  logic                     br_en,
  input  logic                     br_cond,
  input  logic                     br_mode,
  input  logic                     taken,
  input  logic [7:0]               br_off,
  input  logic [$clog2(LUT_N)-1:0] br_idx,
  input  logic                     lut_we,
  input  logic [$clog2(LUT_N)-1:0] lut_idx,
  input  logic [PC_W-1:0]          lut_data,
  output logic [PC_W-1:0]          pc_o,
  output logic                     running,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] lut_q [LUT_N];
  logic [PC_W-1:0] lut_d [LUT_N];
  logic [PC_W-1:0] off_ext;
  logic            br_go;

  assign off_ext = {{(PC_W-8){br_off[7]}}, br_off};
  assign br_go   = br_en && (!br_cond || taken);

  // Target table: write takes effect at the edge; branch reads see lut_q (old value).
  always_comb begin
    for (int unsigned i = 0; i < LUT_N; i++) begin
      lut_d[i] = lut_q[i];
    end
    if (lut_we) begin
      lut_d[lut_idx] = lut_data;
    end
  end

  // Next state, next PC and next flags.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    running_d = running_q;
    done_d    = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = '0;
          running_d = 1'b1;
          done_d    = 1'b0;
        end
      end
      RUN: begin
        if (stall) begin
          pc_d = pc_q;
        end else if (halt_i) begin
          state_d   = DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
        end else if (br_go) begin
          pc_d = br_mode ? lut_q[br_idx] : pc_q + off_ext;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        pc_d      = '0;
        running_d = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

  // State, PC, flags and table registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
      for (int unsigned i = 0; i < LUT_N; i++) begin
        lut_q[i] <= lut_d[i];
      end
    end
  end

  assign pc_o    = pc_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed test-plan scenarios plus randomized stimulus checked
// against a behavioural model of the sequencing rules.
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       reset, start, stall, halt_i, br_en, br_cond, br_mode, taken;
  logic [7:0] br_off;
  logic [2:0] br_idx, lut_idx;
  logic       lut_we;
  logic [9:0] lut_data;
  logic [9:0] pc_o;
  logic       running, done;

  int n_cmp = 0;
  int n_err = 0;

  // model: 0 = idle, 1 = run, 2 = done
  int m_st;
  int m_pc;
  int m_lut [8];

  pc_unit #(.PC_W(10), .LUT_N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_i(halt_i),
    .br_en(br_en), .br_cond(br_cond), .br_mode(br_mode), .taken(taken),
    .br_off(br_off), .br_idx(br_idx), .lut_we(lut_we), .lut_idx(lut_idx),
    .lut_data(lut_data), .pc_o(pc_o), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic ctl_clear();
    reset = 0; start = 0; stall = 0; halt_i = 0; br_en = 0; br_cond = 0;
    br_mode = 0; taken = 0; br_off = 0; br_idx = 0; lut_we = 0; lut_idx = 0;
    lut_data = 0;
  endtask

  task automatic model_update();
    int nxt;
    int off;
    if (reset) begin
      m_st = 0;
      m_pc = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
      return;
    end
    nxt = m_pc;
    if (m_st == 0 || m_st == 2) begin
      if (start) begin
        m_st = 1;
        nxt = 0;
      end
    end else if (!stall) begin
      if (halt_i) begin
        m_st = 2;
      end else if (br_en && (!br_cond || taken)) begin
        if (br_mode) begin
          nxt = m_lut[br_idx];
        end else begin
          off = (br_off >= 128) ? int'(br_off) - 256 : int'(br_off);
          nxt = (m_pc + off + 1024) % 1024;
        end
      end else begin
        nxt = (m_pc + 1) % 1024;
      end
    end
    m_pc = nxt;
    if (lut_we) m_lut[lut_idx] = int'(lut_data);
  endtask

  // one clock: model follows the sampled inputs, outputs checked 1 time unit later
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("pc", int'(pc_o), m_pc);
    chk("running", int'(running), (m_st == 1) ? 1 : 0);
    chk("done", int'(done), (m_st == 2) ? 1 : 0);
    chk("excl", int'(running & done), 0);
    ctl_clear();
  endtask

  task automatic rel_br(input int off);
    br_en = 1; br_cond = 0; br_mode = 0; br_off = 8'(off);
    step();
  endtask

  initial begin
    ctl_clear();
    m_st = 0;
    m_pc = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
    reset = 1; step();
    reset = 1; step();
    chk("rst_pc", int'(pc_o), 0);
    chk("rst_run", int'(running), 0);

    // start then free-run
    start = 1; step();
    chk("start_pc", int'(pc_o), 0);
    chk("start_run", int'(running), 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq_pc", int'(pc_o), i);
    end
    chk("seq_done", int'(done), 0);

    // conditional relative branch at PC=20
    rel_br(15);
    chk("at20", int'(pc_o), 20);
    br_en = 1; br_cond = 1; br_mode = 0; br_off = 8'hF6; taken = 1; step();
    chk("br_taken", int'(pc_o), 10);
    rel_br(10);
    br_en = 1; br_cond = 1; br_mode = 0; br_off = 8'hF6; taken = 0; step();
    chk("br_fall", int'(pc_o), 21);

    // same-edge write and absolute branch to index 3 reads old value 0
    lut_we = 1; lut_idx = 3; lut_data = 10'h3F0;
    br_en = 1; br_mode = 1; br_idx = 3; step();
    chk("same_edge", int'(pc_o), 0);
    rel_br(7);
    lut_we = 1; lut_idx = 3; lut_data = 10'h3F0; step();
    chk("wr_pc8", int'(pc_o), 8);
    br_en = 1; br_mode = 1; br_cond = 0; br_idx = 3; step();
    chk("abs_br", int'(pc_o), 10'h3F0);

    // wrap and most-negative offset
    rel_br(15);
    chk("at3ff", int'(pc_o), 10'h3FF);
    step();
    chk("wrap", int'(pc_o), 0);
    rel_br(5);
    br_en = 1; br_off = 8'h80; step();
    chk("off_m128", int'(pc_o), 10'h385);

    // stall masks halt; release halts; restart
    lut_we = 1; lut_idx = 2; lut_data = 10'd9; step();
    br_en = 1; br_mode = 1; br_idx = 2; step();
    chk("at9", int'(pc_o), 9);
    stall = 1; halt_i = 1; step();
    chk("stall_pc", int'(pc_o), 9);
    chk("stall_done", int'(done), 0);
    halt_i = 1; step();
    chk("halt_done", int'(done), 1);
    chk("halt_pc", int'(pc_o), 9);
    step();
    chk("done_hold", int'(pc_o), 9);
    start = 1; step();
    chk("restart_pc", int'(pc_o), 0);
    chk("restart_run", int'(running), 1);
    chk("restart_done", int'(done), 0);

    // reset mid-run clears table and returns to idle
    lut_we = 1; lut_idx = 1; lut_data = 10'h2AA;
    rel_br(42);
    chk("at42", int'(pc_o), 42);
    reset = 1; br_en = 1; br_off = 8'd3; step();
    chk("mid_rst_pc", int'(pc_o), 0);
    chk("mid_rst_run", int'(running), 0);
    step(); step();
    chk("idle_hold", int'(pc_o), 0);
    start = 1; step();
    br_en = 1; br_mode = 1; br_idx = 1; step();
    chk("lut_cleared", int'(pc_o), 0);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 7) == 0);
      stall    = ($urandom_range(0, 5) == 0);
      halt_i   = ($urandom_range(0, 39) == 0);
      br_en    = ($urandom_range(0, 2) == 0);
      br_cond  = 1'($urandom);
      br_mode  = 1'($urandom);
      taken    = 1'($urandom);
      br_off   = 8'($urandom);
      br_idx   = 3'($urandom);
      lut_we   = ($urandom_range(0, 3) == 0);
      lut_idx  = 3'($urandom);
      lut_data = 10'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
